bash_f_round_seq: RTL and testbench

//   Round sequencer for the bash-f permutation core. Accepts a start request, then produces the
//   per-round constant and round index consumed by the bash-f round datapath.

---
 rtl/bash_f_round_seq.sv | 146 ++++++++++++++
 tb/tb_bash_f_round_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bash_f_round_seq.sv
// bash_f_round_seq
//   Round sequencer for the bash-f permutation core. After a start request it
//   presents the round index and 64-bit round constant (storage form) to the
//   round datapath. It steps to the next round whenever the datapath signals
//   adv_i. The constant LFSR is iterated internally.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   start_i      start a permutation (honoured only in IDLE)
//   adv_i        datapath consumed the current constant; advance
//   abort_i      abandon the current run (only with BASH_F_SEQ_ABORT_EN)
//   busy_o       high in RUN and DONE
//   const_vld_o  round_o/const_o valid (RUN only)
//   round_o      round index, 1..ROUNDS in RUN, 0 otherwise
//   const_o      current round constant, storage (byte-swapped) form
//   last_o       valid and on the final round
//   done_o       one-cycle pulse after the final round was consumed
//
// Configuration
//   BASH_F_SEQ_ABORT_EN  adds abort_i. abort_i takes priority over adv_i in
//                        RUN and returns to IDLE without a done_o pulse.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start_i; round=0, const=C_INIT
// RUN   | presenting round 1..ROUNDS; advances on adv_i
// DONE  | one-cycle done_o pulse; returns to IDLE unconditionally
module bash_f_round_seq #(
  parameter int          ROUNDS = 24,
  parameter logic [63:0] C_INIT = 64'hB194BAC80A08F53B,
  parameter logic [63:0] C_POLY = 64'hAED8E07F99E12BDC,
  localparam int         RW     = $clog2(ROUNDS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          adv_i,
`ifdef BASH_F_SEQ_ABORT_EN
  input  logic          abort_i,
`endif
  output logic          busy_o,
  output logic          const_vld_o,
  output logic [RW-1:0] round_o,
  output logic [63:0]   const_o,
  output logic          last_o,
  output logic          done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [RW-1:0] ROUND_MAX = RW'(ROUNDS);
  localparam logic [RW-1:0] ROUND_ONE = RW'(1);

  state_t        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [63:0]   const_q, const_d;

  function automatic logic [63:0] bswap64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = v[8*(7-i) +: 8];
    end
    return r;
  endfunction

  // The LFSR is defined on the integer view of the constant. The register
  // holds the byte-swapped storage view, so the value is swapped in, shifted,
  // and swapped out. Storage bit 56 is the integer LSB.
  function automatic logic [63:0] next_const(input logic [63:0] c);
    logic [63:0] y;
    y = bswap64(bswap64(c) >> 1);
    if (c[56]) begin
      y = y ^ C_POLY;
    end
    return y;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      const_q <= C_INIT;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      const_q <= const_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    const_d = const_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          round_d = ROUND_ONE;
          const_d = C_INIT;
        end
      end
      RUN: begin
`ifdef BASH_F_SEQ_ABORT_EN
        if (abort_i) begin
          state_d = IDLE;
          round_d = '0;
          const_d = C_INIT;
        end else
`endif
        if (adv_i) begin
          if (round_q == ROUND_MAX) begin
            state_d = DONE;
            round_d = '0;
            const_d = C_INIT;
          end else begin
            round_d = round_q + ROUND_ONE;
            const_d = next_const(const_q);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
        const_d = C_INIT;
      end
    endcase
  end

  // Every output is a register or a decode of registered state, so there is
  // no combinational path from any input.
  assign busy_o      = (state_q == RUN) || (state_q == DONE);
  assign const_vld_o = (state_q == RUN);
  assign round_o     = round_q;
  assign const_o     = const_q;
  assign last_o      = (state_q == RUN) && (round_q == ROUND_MAX);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_bash_f_round_seq.sv
module tb_bash_f_round_seq;

  localparam int          NR       = 24;
  localparam logic [63:0] C_INIT   = 64'hB194BAC80A08F53B;
  localparam logic [63:0] INIT_INT = 64'h3BF5080AC8BA94B1;
  localparam logic [63:0] POLY_INT = 64'hDC2BE1997FE0D8AE;
  localparam logic [63:0] C2_STORE = 64'hF692BD1B9C65D1C1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        adv_i = 1'b0;
`ifdef BASH_F_SEQ_ABORT_EN
  logic        abort_i = 1'b0;
`endif
  logic        busy_o;
  logic        const_vld_o;
  logic [4:0]  round_o;
  logic [63:0] const_o;
  logic        last_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  round;
    logic [63:0] c;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_int [1:NR];

  bash_f_round_seq dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .adv_i       (adv_i),
`ifdef BASH_F_SEQ_ABORT_EN
    .abort_i     (abort_i),
`endif
    .busy_o      (busy_o),
    .const_vld_o (const_vld_o),
    .round_o     (round_o),
    .const_o     (const_o),
    .last_o      (last_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference LFSR on the integer view of the constant.
  function automatic logic [63:0] lfsr_int(input logic [63:0] x);
    logic [63:0] n;
    n = x >> 1;
    if (x[0]) n = n ^ POLY_INT;
    return n;
  endfunction

  function automatic logic [63:0] to_store(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(7-i) +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run();
    exp_t e;
    for (int r = 1; r <= NR; r++) begin
      e.round = 5'(r);
      e.c     = to_store(exp_int[r]);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; adv_i = 1'b0;
    tick(); tick();
    checks++;
    if (busy_o !== 1'b0 || const_vld_o !== 1'b0 || round_o !== 5'd0 ||
        const_o !== C_INIT || last_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b vld=%b round=%0d const=%h last=%b done=%b required 0 0 0 %h 0 0",
               busy_o, const_vld_o, round_o, const_o, last_o, done_o, C_INIT);
    end
    rst = 1'b0;
    adv_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (busy_o !== 1'b0 || round_o !== 5'd0 || const_o !== C_INIT) begin
        errors++;
        $display("FAIL adv_in_idle: busy=%b round=%0d const=%h required 0 0 %h",
                 busy_o, round_o, const_o, C_INIT);
      end
    end
    adv_i = 1'b0;
  endtask

  task automatic test_full_run();
    exp_t e;
    push_run();
    start_i = 1'b1; adv_i = 1'b1;
    for (int k = 1; k <= NR + 2; k++) begin
      tick();
      start_i = 1'b0;
      if (k <= NR) begin
        e = sb.pop_front();
        checks++;
        if (round_o !== e.round || const_o !== e.c || const_vld_o !== 1'b1 ||
            busy_o !== 1'b1 || done_o !== 1'b0) begin
          errors++;
          $display("FAIL full_run_round%0d: round=%0d const=%h vld=%b busy=%b done=%b required %0d %h 1 1 0",
                   k, round_o, const_o, const_vld_o, busy_o, done_o, e.round, e.c);
        end
        checks++;
        if (last_o !== (k == NR)) begin
          errors++;
          $display("FAIL full_run_last%0d: last=%b required %b", k, last_o, (k == NR));
        end
        if (k == 1) begin
          checks++;
          if (const_o !== C_INIT) begin
            errors++;
            $display("FAIL round1_const: const=%h required %h", const_o, C_INIT);
          end
        end
        if (k == 2) begin
          checks++;
          if (const_o !== C2_STORE) begin
            errors++;
            $display("FAIL round2_const: const=%h required %h", const_o, C2_STORE);
          end
        end
      end else if (k == NR + 1) begin
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || const_vld_o !== 1'b0 ||
            round_o !== 5'd0 || const_o !== C_INIT) begin
          errors++;
          $display("FAIL full_run_done: done=%b busy=%b vld=%b round=%0d const=%h required 1 1 0 0 %h",
                   done_o, busy_o, const_vld_o, round_o, const_o, C_INIT);
        end
      end else begin
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
          errors++;
          $display("FAIL full_run_idle: busy=%b done=%b required 0 0", busy_o, done_o);
        end
      end
    end
    adv_i = 1'b0;
  endtask

  task automatic test_random_adv();
    exp_t e;
    bit   seen_done = 1'b0;
    int   cycles = 0;
    push_run();
    start_i = 1'b1;
    adv_i = 1'($urandom_range(0, 1));
    while (!seen_done && cycles < 400) begin
      tick();
      start_i = 1'b0;
      cycles++;
      if (const_vld_o) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rand_extra_round: round=%0d const=%h required no valid round", round_o, const_o);
        end else begin
          e = sb[0];
          if (round_o !== e.round || const_o !== e.c || last_o !== (e.round == 5'(NR))) begin
            errors++;
            $display("FAIL rand_round: round=%0d const=%h last=%b required %0d %h %b",
                     round_o, const_o, last_o, e.round, e.c, (e.round == 5'(NR)));
          end
        end
      end
      if (done_o) seen_done = 1'b1;
      adv_i = 1'($urandom_range(0, 1));
      if (const_vld_o && adv_i && sb.size() > 0) void'(sb.pop_front());
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL rand_timeout: done_o=0 after %0d cycles required done_o=1", cycles);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rand_leftover: %0d rounds unconsumed required 0", sb.size());
    end
    sb.delete();
    adv_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rand_back_idle: busy=%b required 0", busy_o);
    end
  endtask

  task automatic test_back_to_back();
    int p;
    start_i = 1'b1; adv_i = 1'b1;
    for (int k = 1; k <= 2 * (NR + 2); k++) begin
      tick();
      p = ((k - 1) % (NR + 2)) + 1;
      checks++;
      if (p <= NR) begin
        if (const_vld_o !== 1'b1 || round_o !== 5'(p) || const_o !== to_store(exp_int[p]) || done_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b_round k=%0d: vld=%b round=%0d const=%h done=%b required 1 %0d %h 0",
                   k, const_vld_o, round_o, const_o, done_o, p, to_store(exp_int[p]));
        end
      end else if (p == NR + 1) begin
        if (done_o !== 1'b1 || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done k=%0d: done=%b busy=%b required 1 1", k, done_o, busy_o);
        end
      end else begin
        if (busy_o !== 1'b0 || round_o !== 5'd0 || done_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b_idle k=%0d: busy=%b round=%0d done=%b required 0 0 0",
                   k, busy_o, round_o, done_o);
        end
      end
    end
    start_i = 1'b0; adv_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stop: busy=%b required 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; adv_i = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      start_i = 1'b0;
    end
    checks++;
    if (round_o !== 5'd10) begin
      errors++;
      $display("FAIL rstmid_reach10: round=%0d required 10", round_o);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (busy_o !== 1'b0 || round_o !== 5'd0 || const_o !== C_INIT ||
        done_o !== 1'b0 || const_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: busy=%b round=%0d const=%h done=%b vld=%b required 0 0 %h 0 0",
               busy_o, round_o, const_o, done_o, const_vld_o, C_INIT);
    end
    rst = 1'b0; adv_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet: done=%b busy=%b required 0 0", done_o, busy_o);
      end
    end
    test_full_run();
  endtask

`ifdef BASH_F_SEQ_ABORT_EN
  task automatic test_abort();
    int cyc = 0;
    start_i = 1'b1; adv_i = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start_i = 1'b0;
    end
    checks++;
    if (round_o !== 5'd5) begin
      errors++;
      $display("FAIL abort_reach5: round=%0d required 5", round_o);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || round_o !== 5'd0 || const_o !== C_INIT || done_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: busy=%b round=%0d const=%h done=%b required 0 0 %h 0",
               busy_o, round_o, const_o, done_o, C_INIT);
    end
    adv_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (done_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: done=%b required 0", done_o);
      end
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if (round_o !== 5'd1 || const_o !== C_INIT) begin
      errors++;
      $display("FAIL abort_restart: round=%0d const=%h required 1 %h", round_o, const_o, C_INIT);
    end
    adv_i = 1'b1;
    while (busy_o && cyc < 40) begin
      tick();
      cyc++;
    end
    adv_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_drain: busy=%b after %0d cycles required 0", busy_o, cyc);
    end
  endtask
`endif

  initial begin
    exp_int[1] = INIT_INT;
    for (int r = 2; r <= NR; r++) exp_int[r] = lfsr_int(exp_int[r-1]);

    test_reset();
    test_full_run();
    test_random_adv();
    test_back_to_back();
    test_reset_mid();
`ifdef BASH_F_SEQ_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
